// File: rtl/cu_sequencer.sv
// Hardwired T0..T5 control unit for the single-bus datapath: fetch, ALU execute, halt and fault handling.
// Optional single-step mode (PAUSE state and step input) is enabled by defining CU_SINGLE_STEP_EN.
module cu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned OPW         = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
`ifdef CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  alu_op,
    output logic        rout_en,
    output logic        rin_en,
    output logic [3:0]  rout_sel,
    output logic [3:0]  rin_sel,
    output logic        run,
    output logic        fault,
    output logic [2:0]  step_t
);

    localparam int unsigned CNT_W = 8;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_HALT  = 4'd7,
`ifdef CU_SINGLE_STEP_EN
        S_PAUSE = 4'd9,
`endif
        S_FAULT = 4'd8
    } state_t;

`ifdef CU_SINGLE_STEP_EN
    localparam state_t S_END = S_PAUSE;
`else
    localparam state_t S_END = S_T0;
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic [OPW-1:0]     opcode;
    logic [3:0]         ra, rb, rc;
    logic               is_bin, is_un, is_nop, is_halt;
    logic               unused_ir;

    assign opcode    = ir[31 -: OPW];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign cnt_inc   = cnt + CNT_W'(1);

    assign is_bin  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_un   = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);

    // State and T1 wait counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state; mem_rdy wins over the timeout when both land on the same edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_RST: state_d = S_END;
            S_T0:  state_d = S_T1;
            S_T1: begin
                if (mem_rdy) begin
                    state_d = S_T2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MEM_TIMEOUT)) state_d = S_FAULT;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (is_bin || is_un) state_d = S_T4;
                else if (is_nop)     state_d = S_END;
                else if (is_halt)    state_d = S_HALT;
                else                 state_d = S_FAULT;
            end
            S_T4:    state_d = is_bin ? S_T5 : S_END;
            S_T5:    state_d = S_END;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: state_d = step ? S_T0 : S_PAUSE;
`endif
            default: state_d = S_FAULT;
        endcase
    end

    // Moore strobe decode; operand fields are read straight from ir from T3 on
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        alu_op   = '0;
        rout_en  = 1'b0;
        rin_en   = 1'b0;
        rout_sel = '0;
        rin_sel  = '0;
        run      = 1'b0;
        fault    = 1'b0;
        step_t   = 3'd7;
        case (state)
            S_T0: begin
                step_t = 3'd0;
                run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
            end
            S_T1: begin
                step_t = 3'd1;
                run    = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
                if (cnt == '0) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T2: begin
                step_t = 3'd2;
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                step_t = 3'd3;
                run    = 1'b1;
                if (is_bin) begin
                    rout_en  = 1'b1;
                    rout_sel = rb;
                    Yin      = 1'b1;
                end else if (is_un) begin
                    rout_en  = 1'b1;
                    rout_sel = rb;
                    alu_op   = 5'(opcode);
                    Zin      = 1'b1;
                end
            end
            S_T4: begin
                step_t = 3'd4;
                run    = 1'b1;
                if (is_bin) begin
                    rout_en  = 1'b1;
                    rout_sel = rc;
                    alu_op   = 5'(opcode);
                    Zin      = 1'b1;
                end else begin
                    Zlowout = 1'b1;
                    rin_en  = 1'b1;
                    rin_sel = ra;
                end
            end
            S_T5: begin
                step_t  = 3'd5;
                run     = 1'b1;
                Zlowout = 1'b1;
                rin_en  = 1'b1;
                rin_sel = ra;
            end
            S_FAULT: fault = 1'b1;
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: step_t = 3'd6;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: random and directed instructions against a per-cycle step-table model.
// Also builds with CU_SINGLE_STEP_EN defined, in which case PAUSE cycles are modelled.
module tb_cu_sequencer;

    localparam int TO = 15;
`ifdef CU_SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    typedef struct packed {
        logic       pcout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zin, incpc, read;
        logic [4:0] alu_op;
        logic       rout_en, rin_en;
        logic [3:0] rout_sel, rin_sel;
        logic       run, fault;
        logic [2:0] step_t;
    } out_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        mem_rdy = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    logic        step_drv = 1'b1;
`endif
    logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
    logic [4:0]  alu_op;
    logic        rout_en, rin_en;
    logic [3:0]  rout_sel, rin_sel;
    logic        run, fault;
    logic [2:0]  step_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cu_sequencer #(.MEM_TIMEOUT(TO), .OPW(5)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
`ifdef CU_SINGLE_STEP_EN
        .step(step_drv),
`endif
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .IncPC(IncPC), .Read(Read),
        .alu_op(alu_op), .rout_en(rout_en), .rin_en(rin_en), .rout_sel(rout_sel),
        .rin_sel(rin_sel), .run(run), .fault(fault), .step_t(step_t)
    );

    function automatic out_t base(input logic [2:0] st, input logic r);
        out_t o;
        o        = '0;
        o.step_t = st;
        o.run    = r;
        return o;
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Monitor: bus-source exclusivity plus per-cycle scoreboard compare at the falling edge
    always @(negedge clk) begin
        out_t a;
        out_t e;
        assert ($onehot0({PCout, Zlowout, MDRout, rout_en})) else begin
            errors++;
            $display("FAIL bus_onehot t=%0t got PCout=%b Zlowout=%b MDRout=%b rout_en=%b want at most one",
                     $time, PCout, Zlowout, MDRout, rout_en);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pcout = PCout;   a.zlowout = Zlowout; a.mdrout = MDRout; a.marin = MARin;
            a.pcin  = PCin;    a.mdrin   = MDRin;   a.irin   = IRin;   a.yin   = Yin;
            a.zin   = Zin;     a.incpc   = IncPC;   a.read   = Read;   a.alu_op = alu_op;
            a.rout_en = rout_en; a.rin_en = rin_en; a.rout_sel = rout_sel; a.rin_sel = rin_sel;
            a.run = run; a.fault = fault; a.step_t = step_t;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs_step%0d t=%0t got %b want %b", e.step_t, $time, a, e);
            end
        end
    end

    task automatic cycle(input out_t e, input logic rdy, input logic stp);
        @(posedge clk);
        #1;
        mem_rdy = rdy;
`ifdef CU_SINGLE_STEP_EN
        step_drv = stp;
`else
        if (stp) ;
`endif
        exp_q.push_back(e);
    endtask

    // Reset asserted and released between edges; both cycles must show the reset vector
    task automatic do_reset();
        @(posedge clk);
        #2;
        clr = 1'b0;
        exp_q.push_back(base(3'd7, 1'b0));
        @(posedge clk);
        #2;
        clr = 1'b1;
        exp_q.push_back(base(3'd7, 1'b0));
    endtask

    // One instruction; d = T1 cycles before mem_rdy (>= TO means never)
    task automatic run_instr(input logic [31:0] instr, input int d, input bit abort4, input int hold);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         bin, un, nop;
        out_t       o;
        int         n;
        op  = instr[31:27];
        ra  = instr[26:23];
        rb  = instr[22:19];
        rc  = instr[18:15];
        bin = op inside {5'd3, 5'd4, 5'd5, 5'd6};
        un  = op inside {5'd17, 5'd18};
        nop = (op == 5'd26);
        if (SS) begin
            for (int i = 0; i < hold; i++) cycle(base(3'd6, 1'b0), rnd(), 1'b0);
            cycle(base(3'd6, 1'b0), rnd(), 1'b1);
        end
        o = base(3'd0, 1'b1);
        o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin = 1'b1;
        cycle(o, rnd(), 1'b1);
        ir = $urandom;
        n = (d < TO) ? d + 1 : TO;
        for (int i = 0; i < n; i++) begin
            o = base(3'd1, 1'b1);
            o.read = 1'b1; o.mdrin = 1'b1;
            if (i == 0) begin
                o.zlowout = 1'b1; o.pcin = 1'b1;
            end
            cycle(o, 1'(i == d), 1'b1);
        end
        if (d >= TO) begin
            o = base(3'd7, 1'b0);
            o.fault = 1'b1;
            repeat (5) cycle(o, rnd(), 1'b1);
            do_reset();
            return;
        end
        o = base(3'd2, 1'b1);
        o.mdrout = 1'b1; o.irin = 1'b1;
        cycle(o, rnd(), 1'b1);
        o = base(3'd3, 1'b1);
        if (bin) begin
            o.rout_en = 1'b1; o.rout_sel = rb; o.yin = 1'b1;
        end else if (un) begin
            o.rout_en = 1'b1; o.rout_sel = rb; o.alu_op = op; o.zin = 1'b1;
        end
        cycle(o, rnd(), 1'b1);
        ir = instr;
        if (!(bin || un || nop)) begin
            o = base(3'd7, 1'b0);
            o.fault = (op != 5'd27);
            repeat (22) cycle(o, rnd(), 1'b1);
            do_reset();
            return;
        end
        if (nop) return;
        if (abort4) begin
            do_reset();
            return;
        end
        o = base(3'd4, 1'b1);
        if (bin) begin
            o.rout_en = 1'b1; o.rout_sel = rc; o.alu_op = op; o.zin = 1'b1;
        end else begin
            o.zlowout = 1'b1; o.rin_en = 1'b1; o.rin_sel = ra;
        end
        cycle(o, rnd(), 1'b1);
        if (bin) begin
            o = base(3'd5, 1'b1);
            o.zlowout = 1'b1; o.rin_en = 1'b1; o.rin_sel = ra;
            cycle(o, rnd(), 1'b1);
        end
    endtask

    initial begin
        logic [4:0]  ops [8];
        logic [4:0]  op;
        logic [31:0] instr;
        int          r;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd17, 5'd18, 5'd26, 5'd26};

        do_reset();
        run_instr(32'h8808_0000, 0, 1'b0, 0);
        run_instr(32'h1891_8000, 0, 1'b0, 0);
        run_instr(32'h8808_0000, 4, 1'b0, 3);
        run_instr(32'h1891_8000, TO - 1, 1'b0, 0);
        run_instr(32'h8808_0000, TO + 5, 1'b0, 0);
        run_instr(32'hD800_0000, 1, 1'b0, 0);
        run_instr(32'hF800_0000, 2, 1'b0, 0);
        run_instr(32'h8808_0000, 0, 1'b1, 0);
        run_instr(32'h9000_0000, 1, 1'b0, 1);

        for (int k = 0; k < 60; k++) begin
            op    = ops[$urandom_range(0, 7)];
            instr = {op, 27'($urandom)};
            r     = int'($urandom_range(0, 9));
            run_instr(instr, (r < 8) ? r : TO - 1, 1'b0, int'($urandom_range(0, 2)));
        end
        run_instr(32'hA000_0000, 0, 1'b0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
